// File: rtl/ez90_pkg.sv
// Shared types and sizing for the ez90 reorder buffer.
package ez90_pkg;

    localparam int unsigned ROB_DEPTH = 64;
    localparam int unsigned ROB_IDX_W = 6;
    localparam int unsigned ROB_CNT_W = 7;

    // Renamed micro-op as delivered by the rename stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
        logic [7:0]  op;
    } ez90_uop_rn_t;

    // One ROB slot; status bits plus payload.
    typedef struct packed {
        logic         valid;
        logic         done;
        logic         has_trap;
        logic [31:0]  trap_cause;
        ez90_uop_rn_t uop;
    } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Rename/writeback/commit bundle between the pipeline and the reorder buffer.
// master = pipeline side, slave = ROB.
interface rob_if;
    import ez90_pkg::*;

    logic                 alloc_valid;
    ez90_uop_rn_t         alloc_uop;
    logic                 alloc_ready;
    logic [ROB_IDX_W-1:0] alloc_idx;

    logic                 wb_valid;
    logic [ROB_IDX_W-1:0] wb_idx;
    logic                 wb_has_trap;
    logic [31:0]          wb_trap_cause;

    logic                 head_pop;
    logic                 flush;

    logic                 head_valid;
    logic                 head_done;
    logic                 head_has_trap;
    ez90_uop_rn_t         head_uop;
    logic [ROB_IDX_W-1:0] head_idx;
    logic [31:0]          head_trap_cause;
    logic [ROB_CNT_W-1:0] count;
    logic                 trap_flush;

    modport master (
        output alloc_valid, alloc_uop, wb_valid, wb_idx, wb_has_trap, wb_trap_cause,
               head_pop, flush,
        input  alloc_ready, alloc_idx, head_valid, head_done, head_has_trap, head_uop,
               head_idx, head_trap_cause, count, trap_flush
    );

    modport slave (
        input  alloc_valid, alloc_uop, wb_valid, wb_idx, wb_has_trap, wb_trap_cause,
               head_pop, flush,
        output alloc_ready, alloc_idx, head_valid, head_done, head_has_trap, head_uop,
               head_idx, head_trap_cause, count, trap_flush
    );

endinterface

// File: rtl/rob.sv
// Reorder buffer: circular entry array with wrap-bit head/tail pointers.
// Optional macro EZ90_ROB_TRAP_FLUSH_EN: popping a trapped head clears the ROB
// and pulses trap_flush for one cycle.
module rob
    import ez90_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input logic  clk,
    input logic  rst_n,
    rob_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, count;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, trap_q, trap_d;
    ez90_uop_rn_t     uop_q   [DEPTH];
    logic [31:0]      cause_q [DEPTH];

    logic [IdxW-1:0]  head_ix, tail_ix, wb_ix;
    logic             head_valid, alloc_fire, pop_fire, wb_hit, trap_pop, clear;
    logic             trap_flush_pend;
    rob_entry_t       head_ent;

    assign head_ix = head_q[IdxW-1:0];
    assign tail_ix = tail_q[IdxW-1:0];
    assign wb_ix   = bus.wb_idx[IdxW-1:0];
    assign count   = tail_q - head_q;

    assign head_valid = (count != '0);
    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign bus.alloc_ready = (32'(count) < DEPTH) && !bus.flush && !trap_flush_pend;
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
    assign wb_hit          = bus.wb_valid && (32'(bus.wb_idx) < DEPTH) && valid_q[wb_ix];
    // done_q is registered: a writeback to the head in this cycle cannot enable this pop.
    assign pop_fire        = bus.head_pop && head_valid && done_q[head_ix];

`ifdef EZ90_ROB_TRAP_FLUSH_EN
    logic trap_flush_q;

    assign trap_pop        = pop_fire && trap_q[head_ix];
    assign trap_flush_pend = trap_flush_q;
    assign bus.trap_flush  = trap_flush_q;

    // One-cycle pulse after a trapped head retires; an external flush wins and suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_flush_q <= 1'b0;
        end else begin
            trap_flush_q <= trap_pop && !bus.flush;
        end
    end
`else
    assign trap_pop        = 1'b0;
    assign trap_flush_pend = 1'b0;
    assign bus.trap_flush  = 1'b0;
`endif

    assign clear = bus.flush || trap_pop;

    // Next-state for pointers and status bits; clear overrides alloc, writeback and pop.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        trap_d  = trap_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clear) begin
            valid_d = '0;
            done_d  = '0;
            trap_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (wb_hit) begin
                done_d[wb_ix] = 1'b1;
                trap_d[wb_ix] = bus.wb_has_trap;
            end
            if (alloc_fire) begin
                valid_d[tail_ix] = 1'b1;
                done_d[tail_ix]  = 1'b0;
                trap_d[tail_ix]  = 1'b0;
                tail_d           = tail_q + 1'b1;
            end
            if (pop_fire) begin
                valid_d[head_ix] = 1'b0;
                done_d[head_ix]  = 1'b0;
                trap_d[head_ix]  = 1'b0;
                head_d           = head_q + 1'b1;
            end
        end
    end

    // Status and pointer state, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            trap_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            trap_q  <= trap_d;
        end
    end

    // Payload storage is unreset; valid bits gate its meaning. Alloc and wb never share a slot.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            uop_q[tail_ix]   <= bus.alloc_uop;
            cause_q[tail_ix] <= '0;
        end
        if (wb_hit) begin
            cause_q[wb_ix] <= bus.wb_trap_cause;
        end
    end

    // Combinational view of the head slot.
    always_comb begin
        head_ent.valid      = valid_q[head_ix];
        head_ent.done       = done_q[head_ix];
        head_ent.has_trap   = trap_q[head_ix];
        head_ent.trap_cause = cause_q[head_ix];
        head_ent.uop        = uop_q[head_ix];
    end

    assign bus.head_valid      = head_valid;
    assign bus.head_done       = head_ent.done;
    assign bus.head_has_trap   = head_ent.has_trap;
    assign bus.head_trap_cause = head_ent.trap_cause;
    assign bus.head_uop        = head_ent.uop;
    assign bus.head_idx        = ROB_IDX_W'(head_ix);
    assign bus.alloc_idx       = ROB_IDX_W'(tail_ix);
    assign bus.count           = ROB_CNT_W'(count);

endmodule
